// File: rtl/seg7_pattern_decoder.sv
// Active-low 7-segment pattern to hex digit decoder with glitch filter and valid/ready output.
// Define SEG7_HEX_LETTERS_EN to accept the A-F patterns; otherwise only 0-9 decode.

module seg7_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             overflow,
    output logic [ERR_W-1:0] err_count,
    output logic             blank
);

    localparam logic [7:0] RunMax   = 8'(STABLE_CYCLES);
    localparam logic [7:0] AcceptAt = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] PatBlank = 7'h7F;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    logic [6:0] seg_meta;
    logic [6:0] seg_s;
    logic [6:0] seg_prev;
    logic [7:0] run_cnt;
    logic [7:0] run_next;
    logic       armed;
    logic       armed_next;
    logic       seg_changed;
    logic       accept;
    logic       dec_legal;
    logic [3:0] dec_digit;
    logic       acc_digit;
    logic       acc_blank;
    logic       acc_illegal;
    state_e     state;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            seg_meta <= PatBlank;
            seg_s    <= PatBlank;
        end else begin
            seg_meta <= seg_in;
            seg_s    <= seg_meta;
        end
    end

    // Accept fires on the cycle the run length reaches STABLE_CYCLES, so a change is
    // re-arming in the same cycle it is seen (needed when STABLE_CYCLES is 1).
    always_comb begin
        seg_changed = (seg_s != seg_prev);
        run_next    = 8'd0;
        if (!seg_changed) begin
            run_next = (run_cnt == RunMax) ? RunMax : run_cnt + 8'd1;
        end
        accept     = (armed || seg_changed) && (run_next == AcceptAt);
        armed_next = armed || seg_changed;
        if (accept) begin
            armed_next = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            seg_prev <= PatBlank;
            run_cnt  <= 8'd0;
            armed    <= 1'b1;
        end else begin
            seg_prev <= seg_s;
            run_cnt  <= run_next;
            armed    <= armed_next;
        end
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'h0;
        case (seg_s)
            7'b1000000: dec_digit = 4'h0;
            7'b1111001: dec_digit = 4'h1;
            7'b0100100: dec_digit = 4'h2;
            7'b0110000: dec_digit = 4'h3;
            7'b0011001: dec_digit = 4'h4;
            7'b0010010: dec_digit = 4'h5;
            7'b0000010: dec_digit = 4'h6;
            7'b1111000: dec_digit = 4'h7;
            7'b0000000: dec_digit = 4'h8;
            7'b0010000: dec_digit = 4'h9;
`ifdef SEG7_HEX_LETTERS_EN
            7'b0001000: dec_digit = 4'hA;
            7'b0000011: dec_digit = 4'hB;
            7'b1000110: dec_digit = 4'hC;
            7'b0100001: dec_digit = 4'hD;
            7'b0000110: dec_digit = 4'hE;
            7'b0001110: dec_digit = 4'hF;
`endif
            default:    dec_legal = 1'b0;
        endcase
    end

    assign acc_digit   = accept && dec_legal;
    assign acc_blank   = accept && (seg_s == PatBlank);
    assign acc_illegal = accept && !dec_legal && (seg_s != PatBlank);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            err_count <= '0;
            blank     <= 1'b1;
        end else begin
            if (acc_illegal && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (acc_digit) begin
                blank <= 1'b0;
            end else if (acc_blank) begin
                blank <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state       <= StIdle;
            digit_out   <= 4'h0;
            digit_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (acc_digit) begin
                        digit_out   <= dec_digit;
                        digit_valid <= 1'b1;
                        state       <= StHold;
                    end
                end
                StHold: begin
                    if (digit_ready) begin
                        if (acc_digit) begin
                            digit_out <= dec_digit;
                        end else begin
                            digit_valid <= 1'b0;
                            state       <= StIdle;
                        end
                    end else if (acc_digit) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    digit_valid <= 1'b0;
                    state       <= StIdle;
                end
            endcase
        end
    end

    a_valid_in_hold: assert property (@(posedge CLOCK_50) disable iff (!Resetn)
        digit_valid == (state == StHold));

`ifndef SEG7_HEX_LETTERS_EN
    a_decimal_only: assert property (@(posedge CLOCK_50) disable iff (!Resetn)
        digit_out <= 4'h9);
`endif

endmodule

// File: doc/seg7_pattern_decoder.md
Name: seg7_pattern_decoder

Overview:
- Decodes active-low 7-segment patterns (bit0=a … bit6=g) back to a 4-bit hex digit. It is the inverse of the board's digit-to-HEX display driver.
- Used to loop back and check display drive, or to read pattern buses from another board.
- Filters glitches with a stability counter, flags illegal patterns, and hands digits downstream over a valid/ready handshake.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles the synchronised pattern must hold before it is accepted (legal range 1..255).
- ERR_W, 8, width of the saturating illegal-pattern counter.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- seg_in  input  7  active-low segment pattern, asynchronous to CLOCK_50.
- digit_out  output  4  decoded digit, stable while digit_valid=1.
- digit_valid  output  1  digit_out holds an unconsumed digit.
- digit_ready  input  1  consumer accepts digit on a cycle where digit_valid and digit_ready are both 1.
- overflow  output  1  sticky; a digit was dropped because the output was still occupied.
- err_count  output  ERR_W  number of illegal patterns accepted, saturating.
- blank  output  1  last accepted pattern was all-off (7'b1111111).

Behaviour:
- Reset values (Resetn=0, async): both sync stages=7'h7F, run counter=0, armed=1, FSM=IDLE, digit_out=0, digit_valid=0, overflow=0, err_count=0, blank=1.
- Input synchroniser: seg_in passes through a 2-flop synchroniser to give seg_s. All logic uses seg_s only.
- Stability:
  - run counter clears when seg_s differs from its previous-cycle value; otherwise it increments, saturating at STABLE_CYCLES.
  - The pattern is accepted when the counter reaches STABLE_CYCLES-1 with armed=1. Acceptance sets armed=0.
  - A change in seg_s sets armed=1.
  - Result: exactly one accept per stable run.
- Latency: seg_in changes before edge 0 → digit_valid high after edge 1+STABLE_CYCLES (5 edges for the default).
- Decode table (pattern → digit):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Accept outcomes:
  - Legal digit: goes to the output path; blank←0.
  - 1111111: blank←1; no digit, no error.
  - Any other pattern: err_count+1, saturating at all-ones; no digit; blank unchanged.
- FSM IDLE:
  - digit_valid=0.
  - Legal accept: load digit_out, go to HOLD, and digit_valid=1 on the next edge.
- FSM HOLD:
  - digit_valid=1 and digit_out frozen.
  - Handshake without a new accept: go to IDLE.
  - Handshake and legal accept in the same cycle: load the new digit and stay in HOLD, so digit_valid stays 1.
  - Legal accept without handshake: drop the new digit, set overflow=1, keep the old digit.
- overflow and err_count are cleared only by reset.
- Reset mid-operation: everything returns to reset values immediately. The first pattern after reset needs the full synchroniser plus STABLE_CYCLES latency.
- digit_ready is ignored in IDLE.

Optional Feature:
- Macro: SEG7_HEX_LETTERS_EN.
- Defined: the table decodes 0–F as listed.
- Undefined: only 0–9 are legal. The A–F patterns count as illegal (increment err_count, no digit), and digit_out never exceeds 9.

Test Plan:
- Reset with seg_in=1111111 → digit_valid=0, err_count=0, blank=1, overflow=0.
- seg_in=1111001 held, digit_ready=1 → digit_valid=1 with digit_out=1 after exactly 5 edges, high for one cycle, then IDLE. Holding the pattern longer produces no second digit.
- seg_in=0100100 for 3 cycles, then 1111111 → no digit_valid, err_count=0, blank=1.
- seg_in=0101010 held 10 cycles → err_count=1, digit_valid=0. Repeat 300 times with ERR_W=8 → err_count=255.
- digit_ready=0; apply 0110000, then 0011001 (each held 8 cycles) → digit_out=3 held, overflow=1. Raise digit_ready → single handshake, then digit_valid=0.
- seg_in=0001000 held:
  - With macro → digit_out=A (4'hA).
  - Without macro → err_count=1, no digit.
  - Assert Resetn=0 mid-HOLD → digit_valid drops asynchronously.
